// File: rtl/risc_pkg.sv
// risc_pkg: shared widths, ALU function codes and ID/EX control bundle
// rev 1.0
`default_nettype none

package risc_pkg;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int FUNCT_W = 4;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 4'b0000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 4'b0001;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 4'b0010;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 4'b0011;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR = 4'b0100;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 4'b0101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLL = 4'b0110;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL = 4'b0111;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic [FUNCT_W-1:0] funct;
  } idex_ctrl_t;

  // A producer forwards only if it writes a non-zero register matching the source.
  function automatic logic fwd_hit(input logic we, input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] src);
    return we && (rd == src) && (src != REG_ZERO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/operand_forward_sel.sv
// operand_forward_sel: EX/MEM > MEM/WB > register-file operand selection
// rev 1.0
`default_nettype none

module operand_forward_sel
  import risc_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic [XLEN-1:0]   reg_data,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   memwb_result,
  output logic [XLEN-1:0]   data
);

  always_comb begin
    data = reg_data;
    if (fwd_hit(exmem_reg_write, exmem_rd, src)) begin
      data = exmem_result;
    end else if (fwd_hit(memwb_reg_write, memwb_rd, src)) begin
      data = memwb_result;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use bubble
// rev 1.0
`default_nettype none

module id_ex_stage
  import risc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_rs_data,
  input  logic [XLEN-1:0]    id_rt_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_uses_rt,
  input  logic               id_alu_src,
  input  logic [FUNCT_W-1:0] id_funct,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               exmem_reg_write,
  input  logic [REG_AW-1:0]  exmem_rd,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [REG_AW-1:0]  memwb_rd,
  input  logic [XLEN-1:0]    memwb_result,
  input  logic               stall,
  input  logic               flush,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_a,
  output logic [XLEN-1:0]    ex_b,
  output logic [FUNCT_W-1:0] ex_funct,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               load_use_stall
);

  logic              valid_q;
  idex_ctrl_t        ctrl_q;
  logic [XLEN-1:0]   rs_data_q;
  logic [XLEN-1:0]   rt_data_q;
  logic [XLEN-1:0]   imm_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   fwd_rs;
  logic [XLEN-1:0]   fwd_rt;
  logic              clear;

  // Reset, flush and an unstalled load-use all write the same all-zero bubble.
  assign clear = rst || flush || (!stall && load_use_stall);

  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                     alu_src: 1'b0, funct: FUNCT_ADD};
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= REG_ZERO;
      rt_q      <= REG_ZERO;
      rd_q      <= REG_ZERO;
    end else if (!stall) begin
      valid_q          <= id_valid;
      ctrl_q.reg_write <= id_valid && id_reg_write;
      ctrl_q.mem_read  <= id_valid && id_mem_read;
      ctrl_q.mem_write <= id_valid && id_mem_write;
      ctrl_q.alu_src   <= id_alu_src;
      ctrl_q.funct     <= id_funct;
      rs_data_q        <= id_rs_data;
      rt_data_q        <= id_rt_data;
      imm_q            <= id_imm;
      rs_q             <= id_rs;
      rt_q             <= id_rt;
      rd_q             <= id_rd;
    end
  end

  operand_forward_sel u_fwd_rs (
    .src             (rs_q),
    .reg_data        (rs_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .data            (fwd_rs)
  );

  operand_forward_sel u_fwd_rt (
    .src             (rt_q),
    .reg_data        (rt_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .data            (fwd_rt)
  );

  assign ex_valid      = valid_q;
  assign ex_a          = fwd_rs;
  assign ex_b          = ctrl_q.alu_src ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_funct      = ctrl_q.funct;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = valid_q && ctrl_q.reg_write;
  assign ex_mem_read   = valid_q && ctrl_q.mem_read;
  assign ex_mem_write  = valid_q && ctrl_q.mem_write;

  assign load_use_stall = ex_mem_read && (rd_q != REG_ZERO) && id_valid &&
                          ((id_rs == rd_q) || (id_uses_rt && (id_rt == rd_q)));

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table plus hand sequences for stall/flush/reset/load-use
// rev 1.0
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt, id_alu_src;
  logic [3:0]  id_funct;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        stall, flush;
  logic        ex_valid;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [3:0]  ex_funct;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_uses_rt      (id_uses_rt),
    .id_alu_src      (id_alu_src),
    .id_funct        (id_funct),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_mem_write    (id_mem_write),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .stall           (stall),
    .flush           (flush),
    .ex_valid        (ex_valid),
    .ex_a            (ex_a),
    .ex_b            (ex_b),
    .ex_funct        (ex_funct),
    .ex_store_data   (ex_store_data),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .load_use_stall  (load_use_stall)
  );

  typedef struct {
    logic        valid;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic        uses_rt, alu_src;
    logic [3:0]  funct;
    logic        rw, mr, mw;
    logic        xwe; logic [4:0] xrd; logic [31:0] xres;
    logic        wwe; logic [4:0] wrd; logic [31:0] wres;
    logic [31:0] ea, eb, es;
    logic        ev, erw, emw;
    logic [3:0]  ef;
    logic [4:0]  erd;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic urt, input logic asrc,
                          input logic [3:0] fn, input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = urt; id_alu_src = asrc;
    id_funct = fn; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic drive_fwd(input logic xwe, input logic [4:0] xrd, input logic [31:0] xres,
                           input logic wwe, input logic [4:0] wrd, input logic [31:0] wres);
    exmem_reg_write = xwe; exmem_rd = xrd; exmem_result = xres;
    memwb_reg_write = wwe; memwb_rd = wrd; memwb_result = wres;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, {31'b0, ex_valid}, 32'd0);
    chk({tag, ".a"}, ex_a, 32'd0);
    chk({tag, ".b"}, ex_b, 32'd0);
    chk({tag, ".store"}, ex_store_data, 32'd0);
    chk({tag, ".funct"}, {28'b0, ex_funct}, 32'd0);
    chk({tag, ".rd"}, {27'b0, ex_rd}, 32'd0);
    chk({tag, ".ctrl"}, {29'b0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    chk({tag, ".lus"}, {31'b0, load_use_stall}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h000A4321, 32'h000A4322, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                32'h000A4321, 32'h000A4322, 32'h000A4322, 1'b1, 1'b1, 1'b0, 4'h0, 5'd3};
    vecs[1] = '{1'b1, 32'hAAAA0003, 32'hBBBB0004, 32'h0, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd3, 32'h11111111, 1'b1, 5'd3, 32'h22222222,
                32'h11111111, 32'hBBBB0004, 32'hBBBB0004, 1'b1, 1'b1, 1'b0, 4'h1, 5'd11};
    vecs[2] = '{1'b1, 32'hAAAA0003, 32'hBBBB0004, 32'h0, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0,
                1'b0, 5'd3, 32'h11111111, 1'b1, 5'd3, 32'h22222222,
                32'h22222222, 32'hBBBB0004, 32'hBBBB0004, 1'b1, 1'b1, 1'b0, 4'h1, 5'd11};
    vecs[3] = '{1'b1, 32'hCAFE0000, 32'hBBBB0004, 32'h0, 5'd0, 5'd4, 5'd11, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd0, 32'h11111111, 1'b1, 5'd0, 32'h22222222,
                32'hCAFE0000, 32'hBBBB0004, 32'hBBBB0004, 1'b1, 1'b1, 1'b0, 4'h1, 5'd11};
    vecs[4] = '{1'b1, 32'h00000007, 32'h00000099, 32'hFFFFFFF0, 5'd7, 5'd6, 5'd0, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b1,
                1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h00000005,
                32'h00000007, 32'hFFFFFFF0, 32'h00000005, 1'b1, 1'b0, 1'b1, 4'h2, 5'd0};
    vecs[5] = '{1'b1, 32'h00000001, 32'h00000009, 32'h0, 5'd1, 5'd9, 5'd12, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd9, 32'h33333333, 1'b1, 5'd9, 32'h44444444,
                32'h00000001, 32'h33333333, 32'h33333333, 1'b1, 1'b1, 1'b0, 4'h3, 5'd12};
    vecs[6] = '{1'b0, 32'h00002222, 32'h00003333, 32'h0, 5'd2, 5'd3, 5'd13, 1'b1, 1'b0, 4'h4, 1'b1, 1'b0, 1'b1,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                32'h00002222, 32'h00003333, 32'h00003333, 1'b0, 1'b0, 1'b0, 4'h4, 5'd13};
    vecs[7] = '{1'b1, 32'h00000088, 32'h000000AA, 32'h0, 5'd8, 5'd10, 5'd14, 1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0,
                1'b1, 5'd9, 32'h99999999, 1'b1, 5'd8, 32'h00000055,
                32'h00000055, 32'h000000AA, 32'h000000AA, 1'b1, 1'b1, 1'b0, 4'h5, 5'd14};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_id(1'b1, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 4'h7, 1'b1, 1'b0, 1'b0);
    drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive_id(vecs[i].valid, vecs[i].rs_data, vecs[i].rt_data, vecs[i].imm, vecs[i].rs, vecs[i].rt,
               vecs[i].rd, vecs[i].uses_rt, vecs[i].alu_src, vecs[i].funct, vecs[i].rw, vecs[i].mr, vecs[i].mw);
      drive_fwd(vecs[i].xwe, vecs[i].xrd, vecs[i].xres, vecs[i].wwe, vecs[i].wrd, vecs[i].wres);
      tick();
      chk($sformatf("v%0d.a", i), ex_a, vecs[i].ea);
      chk($sformatf("v%0d.b", i), ex_b, vecs[i].eb);
      chk($sformatf("v%0d.store", i), ex_store_data, vecs[i].es);
      chk($sformatf("v%0d.valid", i), {31'b0, ex_valid}, {31'b0, vecs[i].ev});
      chk($sformatf("v%0d.rw", i), {31'b0, ex_reg_write}, {31'b0, vecs[i].erw});
      chk($sformatf("v%0d.mw", i), {31'b0, ex_mem_write}, {31'b0, vecs[i].emw});
      chk($sformatf("v%0d.mr", i), {31'b0, ex_mem_read}, 32'd0);
      chk($sformatf("v%0d.funct", i), {28'b0, ex_funct}, {28'b0, vecs[i].ef});
      chk($sformatf("v%0d.rd", i), {27'b0, ex_rd}, {27'b0, vecs[i].erd});
      chk($sformatf("v%0d.lus", i), {31'b0, load_use_stall}, 32'd0);
    end
    drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Load to r5 followed by a dependent reading r5 through rt.
    drive_id(1'b1, 32'h100, 32'h200, 32'h0, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("lu.load_mr", {31'b0, ex_mem_read}, 32'd1);
    drive_id(1'b1, 32'h700, 32'h500, 32'h0, 5'd7, 5'd5, 5'd8, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu.stall_on", {31'b0, load_use_stall}, 32'd1);
    tick();
    chk("lu.bubble_valid", {31'b0, ex_valid}, 32'd0);
    chk("lu.bubble_rw", {31'b0, ex_reg_write}, 32'd0);
    chk("lu.stall_off", {31'b0, load_use_stall}, 32'd0);
    tick();
    chk("lu.dep_valid", {31'b0, ex_valid}, 32'd1);
    chk("lu.dep_rd", {27'b0, ex_rd}, 32'd8);
    chk("lu.dep_b", ex_b, 32'h500);
    chk("lu.dep_lus", {31'b0, load_use_stall}, 32'd0);

    // Same pair, but the dependent does not read rt: no stall.
    drive_id(1'b1, 32'h100, 32'h200, 32'h0, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 32'h700, 32'h500, 32'h0, 5'd7, 5'd5, 5'd8, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("nolu.lus", {31'b0, load_use_stall}, 32'd0);
    tick();
    chk("nolu.valid", {31'b0, ex_valid}, 32'd1);
    chk("nolu.rd", {27'b0, ex_rd}, 32'd8);

    // External stall holds the stage while decode keeps changing.
    drive_id(1'b1, 32'h1234, 32'h5678, 32'h0, 5'd4, 5'd6, 5'd10, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 32'hF000 + i, 32'hE000 + i, 32'h0, 5'd11 + 5'(i), 5'd12, 5'd20 + 5'(i),
               1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 1'b1);
      tick();
      chk($sformatf("stall%0d.a", i), ex_a, 32'h1234);
      chk($sformatf("stall%0d.rd", i), {27'b0, ex_rd}, 32'd10);
      chk($sformatf("stall%0d.funct", i), {28'b0, ex_funct}, 32'd3);
      chk($sformatf("stall%0d.mw", i), {31'b0, ex_mem_write}, 32'd0);
    end
    flush = 1'b1;
    tick();
    chk_all_zero("flush_over_stall");
    flush = 1'b0; stall = 1'b0;

    // Stall dominates a pending load-use; the bubble lands once stall drops.
    drive_id(1'b1, 32'h100, 32'h200, 32'h0, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 32'h500, 32'h0, 32'h0, 5'd5, 5'd0, 5'd9, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    tick();
    chk("stlu.held_mr", {31'b0, ex_mem_read}, 32'd1);
    chk("stlu.lus", {31'b0, load_use_stall}, 32'd1);
    stall = 1'b0;
    tick();
    chk("stlu.bubble", {31'b0, ex_valid}, 32'd0);
    tick();
    chk("stlu.dep_rd", {27'b0, ex_rd}, 32'd9);

    // Reset raised between edges has no effect until the next edge.
    drive_id(1'b1, 32'hABCD, 32'h0, 32'h0, 5'd3, 5'd0, 5'd7, 1'b0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid.valid", {31'b0, ex_valid}, 32'd1);
    chk("rst_mid.a", ex_a, 32'hABCD);
    @(posedge clk); #1;
    chk_all_zero("rst_edge");
    rst = 1'b0;
    tick();
    chk("post_rst.a", ex_a, 32'hABCD);
    chk("post_rst.valid", {31'b0, ex_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
